// File: rtl/vec_alu_arbiter.sv
// vec_alu_arbiter: two-requester round-robin front end for one shared
// combinational vector ALU. Each accepted operation walks IDLE -> EXEC -> RESP
// and its result is held on res_data until the consumer takes it.
// Optional feature: define VEC_ALU_ARB_PERF_EN to add per-requester
// saturating counters of accepted operations (perf_cnt0 / perf_cnt1).
module vec_alu_arbiter #(
   parameter int N = 20,
   parameter int V = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   input  logic                req1_valid,
   output logic                req0_ready,
   output logic                req1_ready,
   input  logic [V-1:0][N-1:0] req0_a,
   input  logic [V-1:0][N-1:0] req0_b,
   input  logic [V-1:0][N-1:0] req1_a,
   input  logic [V-1:0][N-1:0] req1_b,
   input  logic [2:0]          req0_op,
   input  logic [2:0]          req1_op,
   output logic [V-1:0][N-1:0] alu_a,
   output logic [V-1:0][N-1:0] alu_b,
   output logic [2:0]          alu_op,
   input  logic [V-1:0][N-1:0] alu_result,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [V-1:0][N-1:0] res_data,
   output logic                res_src
`ifdef VEC_ALU_ARB_PERF_EN
   ,
   output logic [15:0]         perf_cnt0,
   output logic [15:0]         perf_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                last_grant;
   logic                grant_sel;
   logic                grant_any;
   logic                accept;
   logic [V-1:0][N-1:0] opa_r;
   logic [V-1:0][N-1:0] opb_r;
   logic [2:0]          op_r;
   logic                src_r;

   // Round-robin pick: on contention favour the side not served last,
   // otherwise serve whichever side is asking.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_grant;
      end else begin
         grant_sel = ~req0_valid;
      end
   end

   // Next-state and ready generation; readies are forced low while in reset.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (rst_n && grant_any) begin
               req0_ready = ~grant_sel;
               req1_ready = grant_sel;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign accept = req0_ready | req1_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the granted operation and remember who was served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_r      <= '0;
         opb_r      <= '0;
         op_r       <= '0;
         src_r      <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         opa_r      <= grant_sel ? req1_a  : req0_a;
         opb_r      <= grant_sel ? req1_b  : req0_b;
         op_r       <= grant_sel ? req1_op : req0_op;
         src_r      <= grant_sel;
         last_grant <= grant_sel;
      end
   end

   // Capture the ALU output on the edge that ends EXEC; held through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data <= '0;
      end else if (state == EXEC) begin
         res_data <= alu_result;
      end
   end

   assign alu_a     = opa_r;
   assign alu_b     = opb_r;
   assign alu_op    = op_r;
   assign res_src   = src_r;
   assign res_valid = (state == RESP);

`ifdef VEC_ALU_ARB_PERF_EN
   // Count accepted operations per requester, sticking at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt0 <= '0;
         perf_cnt1 <= '0;
      end else begin
         if (req0_ready && (perf_cnt0 != 16'hFFFF)) begin
            perf_cnt0 <= perf_cnt0 + 16'd1;
         end
         if (req1_ready && (perf_cnt1 != 16'hFFFF)) begin
            perf_cnt1 <= perf_cnt1 + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vec_alu_arbiter.sv
// Directed testbench for vec_alu_arbiter with a small lane-wise ALU model
// (op 0 = add, op 1 = subtract, others = xor) on the shared ALU port.
module tb_vec_alu_arbiter;

   localparam int N = 20;
   localparam int V = 8;
   typedef logic [V-1:0][N-1:0] vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0;
   logic       req1_valid = 1'b0;
   logic       req0_ready;
   logic       req1_ready;
   vec_t       req0_a = '0;
   vec_t       req0_b = '0;
   vec_t       req1_a = '0;
   vec_t       req1_b = '0;
   logic [2:0] req0_op = '0;
   logic [2:0] req1_op = '0;
   vec_t       alu_a;
   vec_t       alu_b;
   logic [2:0] alu_op;
   vec_t       alu_result;
   logic       res_valid;
   logic       res_ready = 1'b0;
   vec_t       res_data;
   logic       res_src;
`ifdef VEC_ALU_ARB_PERF_EN
   logic [15:0] perf_cnt0;
   logic [15:0] perf_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   vec_alu_arbiter #(.N(N), .V(V)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_src(res_src)
`ifdef VEC_ALU_ARB_PERF_EN
      , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
   );

   always #5 clk = ~clk;

   // Shared combinational ALU model.
   always_comb begin
      alu_result = '0;
      for (int i = 0; i < V; i++) begin
         case (alu_op)
            3'd0:    alu_result[i] = alu_a[i] + alu_b[i];
            3'd1:    alu_result[i] = alu_a[i] - alu_b[i];
            default: alu_result[i] = alu_a[i] ^ alu_b[i];
         endcase
      end
   end

   function automatic vec_t fill(input logic [N-1:0] x);
      vec_t r;
      for (int i = 0; i < V; i++) r[i] = x;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %0b want 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %0b want 0", req1_ready); end
      step(); step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
      checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL reset_res_src: got %0b want 0", res_src); end
      checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h want 0", res_data); end
      checks++; if (alu_a !== '0 || alu_b !== '0 || alu_op !== 3'd0) begin errors++; $display("FAIL reset_operands: got a=%h b=%h op=%0d want 0", alu_a, alu_b, alu_op); end
      req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL idle_no_valid_ready: got %0b%0b want 00", req0_ready, req1_ready); end
      req0_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_grant: got %0b want 1", req0_ready); end
      req0_valid = 1'b0;
      step();
      req1_valid = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL withdrawn_valid_ignored: got ready1=%0b res_valid=%0b want 1 0", req1_ready, res_valid); end
      req1_valid = 1'b0;
      step();
   endtask

   task automatic test_single();
      req0_a = fill(20'd5); req0_b = fill(20'd3); req0_op = 3'd0;
      res_ready = 1'b1; req0_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant: got %0b%0b want 10", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL single_exec: got res_valid=%0b ready0=%0b want 0 0", res_valid, req0_ready); end
      checks++; if (alu_a !== fill(20'd5) || alu_b !== fill(20'd3)) begin errors++; $display("FAIL single_alu_ops: got a=%h b=%h", alu_a, alu_b); end
      step();
      checks++; if (res_valid !== 1'b1 || res_src !== 1'b0) begin errors++; $display("FAIL single_resp: got res_valid=%0b src=%0b want 1 0", res_valid, res_src); end
      checks++; if (res_data !== fill(20'd8)) begin errors++; $display("FAIL single_data: got %h want %h", res_data, fill(20'd8)); end
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_done: got res_valid=%0b want 0", res_valid); end
   endtask

   task automatic test_contention();
      rst_n = 1'b0; #1; rst_n = 1'b1; #1;
      req0_a = fill(20'd10); req0_b = fill(20'd2); req0_op = 3'd0;
      req1_a = fill(20'd7);  req1_b = fill(20'd4); req1_op = 3'd1;
      res_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin errors++; $display("FAIL contention_grant[%0d]: got %0b%0b", i, req0_ready, req1_ready); end
         step();
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL contention_exec_ready[%0d]: got %0b%0b want 00", i, req0_ready, req1_ready); end
         step();
         checks++; if (res_valid !== 1'b1 || res_src !== (i % 2 == 1)) begin errors++; $display("FAIL contention_src[%0d]: got valid=%0b src=%0b", i, res_valid, res_src); end
         checks++; if (res_data !== ((i % 2 == 1) ? fill(20'd3) : fill(20'd12))) begin errors++; $display("FAIL contention_data[%0d]: got %h", i, res_data); end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      vec_t exp;
      req0_a = fill(20'd0); req0_a[0] = 20'hFFFFF; req0_a[3] = 20'd1000;
      req0_b = fill(20'd1); req0_op = 3'd0;
      exp = fill(20'd1); exp[0] = 20'd0; exp[3] = 20'd1001;
      res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
      step();
      req0_valid = 1'b0; req1_valid = 1'b1; req0_a = fill(20'd9);
      step();
      for (int i = 0; i < 5; i++) begin
         checks++; if (res_valid !== 1'b1 || res_data !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%h want 1 %h", i, res_valid, res_data, exp); end
         checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b%0b want 00", i, req0_ready, req1_ready); end
         step();
      end
      res_ready = 1'b1;
      step();
      checks++; if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%0b ready1=%0b want 0 1", res_valid, req1_ready); end
      req1_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_op();
      req0_a = fill(20'd20); req0_b = fill(20'd1); req0_op = 3'd0;
      res_ready = 1'b1; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b0 || res_data !== '0 || alu_a !== '0) begin errors++; $display("FAIL midreset_clear: got valid=%0b data=%h a=%h", res_valid, res_data, alu_a); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %0b%0b want 00", req0_ready, req1_ready); end
      step();
      req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_result[%0d]: got %0b want 0", i, res_valid); end
         step();
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL midreset_next_grant: got %0b%0b want 10", req0_ready, req1_ready); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
   endtask

   task automatic test_req1_only();
      req1_a = fill(20'd50); req1_b = fill(20'd8); req1_op = 3'd1;
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req1_valid = 1'b1;
         #1;
         checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL req1_only_grant[%0d]: got %0b%0b want 01", i, req0_ready, req1_ready); end
         step();
         req1_valid = 1'b0;
         step();
         checks++; if (res_valid !== 1'b1 || res_src !== 1'b1 || res_data !== fill(20'd42)) begin errors++; $display("FAIL req1_only_result[%0d]: got valid=%0b src=%0b data=%h", i, res_valid, res_src, res_data); end
         step();
      end
   endtask

`ifdef VEC_ALU_ARB_PERF_EN
   task automatic test_perf();
      rst_n = 1'b0; #1;
      checks++; if (perf_cnt0 !== 16'd0 || perf_cnt1 !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_cnt0, perf_cnt1); end
      rst_n = 1'b1; res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) req0_valid = 1'b1; else req1_valid = 1'b1;
         step();
         req0_valid = 1'b0; req1_valid = 1'b0;
         step(); step();
      end
      checks++; if (perf_cnt0 !== 16'd3 || perf_cnt1 !== 16'd2) begin errors++; $display("FAIL perf_counts: got %0d %0d want 3 2", perf_cnt0, perf_cnt1); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      test_req1_only();
`ifdef VEC_ALU_ARB_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
